morse_key_decoder: RTL and testbench

Timing-based Morse decoder, the parametrised successor to the pulse-driven decoder. It takes a single straight-key input and classifies each mark as dot or dash from its duration, and detects character and word gaps from silence length. Decoded ASCII (A–Z, 0–9, space, '?') is buffered in a small output FIFO with a valid/ready interface. It sits between the key input pins and the character output/display logic.

---
 rtl/morse_key_decoder.sv | 178 +++++++++++++++++
 tb/tb_morse_key_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// Straight-key Morse decoder: times marks and gaps, builds a heap index per character, queues ASCII.
// Bytes appear one cycle after the committing edge; a full FIFO drops new bytes and sets sticky overflow.
module morse_key_decoder #(
    parameter int UNIT_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter bit WORD_GAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       busy,
    output logic       overflow
);
    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_WGAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [6:0]       idx_q, idx_d;
    logic [2:0]       sym_q, sym_d;
    logic             err_q, err_d;
    logic             push, push_ok, pop, full;
    logic [7:0]       push_dat;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    // Heap index: root 0, dot child 2i+1, dash child 2i+2.
    function automatic logic [7:0] decode(input logic [6:0] idx, input logic err);
        logic [7:0] c;
        c = 8'h3F;
        if (!err) begin
            case (idx)
                7'd1:  c = "E";  7'd2:  c = "T";  7'd3:  c = "I";  7'd4:  c = "A";
                7'd5:  c = "N";  7'd6:  c = "M";  7'd7:  c = "S";  7'd8:  c = "U";
                7'd9:  c = "R";  7'd10: c = "W";  7'd11: c = "D";  7'd12: c = "K";
                7'd13: c = "G";  7'd14: c = "O";  7'd15: c = "H";  7'd16: c = "V";
                7'd17: c = "F";  7'd19: c = "L";  7'd21: c = "P";  7'd22: c = "J";
                7'd23: c = "B";  7'd24: c = "X";  7'd25: c = "C";  7'd26: c = "Y";
                7'd27: c = "Z";  7'd28: c = "Q";
                7'd31: c = "5";  7'd32: c = "4";  7'd34: c = "3";  7'd38: c = "2";
                7'd46: c = "1";  7'd47: c = "6";  7'd55: c = "7";  7'd59: c = "8";
                7'd61: c = "9";  7'd62: c = "0";
                default: c = 8'h3F;
            endcase
        end
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sym_d    = sym_q;
        err_d    = err_q;
        push     = 1'b0;
        push_dat = 8'h00;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        case (state_q)
            S_IDLE: begin
                if (key) begin
                    state_d = S_MARK;
                    cnt_d   = CNT_ONE;
                end
            end
            S_MARK: begin
                if (key) begin
                    cnt_d = cnt_inc;
                end else begin
                    if (sym_q == 3'd5) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d = {idx_q[5:0], 1'b0} + ((cnt_q < DASH_MIN) ? 7'd1 : 7'd2);
                        sym_d = sym_q + 3'd1;
                    end
                    state_d = S_GAP;
                    cnt_d   = CNT_ONE;
                end
            end
            S_GAP: begin
                if (key) begin
                    state_d = S_MARK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DASH_MIN) begin
                        push     = 1'b1;
                        push_dat = decode(idx_q, err_q);
                        idx_d    = 7'd0;
                        sym_d    = 3'd0;
                        err_d    = 1'b0;
                        state_d  = WORD_GAP_EN ? S_WGAP : S_IDLE;
                    end
                end
            end
            S_WGAP: begin
                if (key) begin
                    state_d = S_MARK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WORD_LEN) begin
                        push     = 1'b1;
                        push_dat = 8'h20;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop     = (count_q != '0) && char_ready;
    assign full    = (count_q == FULL_CNT);
    assign push_ok = push && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 7'd0;
            sym_q      <= 3'd0;
            err_q      <= 1'b0;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sym_q      <= sym_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign char_data  = mem_q[rd_ptr_q];
    assign char_valid = (count_q != '0);
    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: directed scenarios plus random keying scored against a dot/dash string model.
module tb_morse_key_decoder;
    localparam int U = 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       key        = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic       busy;
    logic       overflow;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         rnd_ready = 1'b0;

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    morse_key_decoder #(
        .UNIT_CYCLES(U),
        .CNT_W(16),
        .FIFO_DEPTH(4),
        .WORD_GAP_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .char_data(char_data),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Records every byte the consumer accepts on the following rising edge.
    always @(negedge clk) begin
        if (!rst && char_valid && char_ready) got_q.push_back(char_data);
    end

    function automatic logic [7:0] lookup(input string s);
        if (s.len() > 5) return 8'h3F;
        for (int i = 0; i < 36; i++) begin
            if (s == morse_tab[i]) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
        end
        return 8'h3F;
    endfunction

    function automatic void set_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            key = v;
            if (rnd_ready) char_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        key = 1'b0;
        char_ready = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        tests_run++;
        if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", char_valid); end
        tests_run++;
        if (char_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %02h want 00", char_data); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single_dot();
        reset_dut();
        drive(1, 1);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL dot_busy_rise: got %b want 1", busy); end
        drive(1, 2);
        drive(0, 8);
        tests_run++;
        if (char_valid !== 1'b1 || char_data !== 8'h45) begin
            tests_failed++; $display("FAIL dot_latency: got valid=%b data=%02h want 1/45", char_valid, char_data);
        end
        drive(0, 3);
        tests_run++;
        if (char_valid !== 1'b1 || char_data !== 8'h45) begin
            tests_failed++; $display("FAIL dot_hold: got valid=%b data=%02h want 1/45", char_valid, char_data);
        end
        char_ready = 1'b1;
        drive(0, 8);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL dot_busy_wgap: got %b want 1", busy); end
        drive(0, 1);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL dot_busy_fall: got %b want 0", busy); end
        drive(0, 20);
        set_exp("E ");
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL dot_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL dot_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_threshold();
        reset_dut();
        char_ready = 1'b1;
        drive(1, 7); drive(0, 8);
        drive(1, 8); drive(0, 8);
        drive(1, 1); drive(0, 7); drive(1, 8); drive(0, 8);
        drive(0, 30);
        set_exp("ETA ");
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL thr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL thr_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_digits();
        reset_dut();
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin drive(1, 2); drive(0, 2); end
        drive(1, 2); drive(0, 8);
        for (int i = 0; i < 5; i++) begin drive(1, 2); drive(0, 2); end
        drive(1, 2); drive(0, 8);
        for (int i = 0; i < 4; i++) begin drive(1, 8); drive(0, 2); end
        drive(1, 8); drive(0, 8);
        drive(0, 30);
        set_exp("5?0 ");
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL dig_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL dig_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        reset_dut();
        for (int i = 0; i < 4; i++) begin drive(1, 1); drive(0, 10); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL full_no_ovf_at4: got %b want 0", overflow); end
        drive(1, 1); drive(0, 10);
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL full_ovf: got %b want 1", overflow); end
        // Let the trailing word space land (and be dropped) while still full.
        drive(0, 12);
        char_ready = 1'b1;
        drive(0, 10);
        set_exp("EEEE");
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL full_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL full_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        tests_run++;
        if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drained: got %b want 0", char_valid); end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_simul_push_pop();
        reset_dut();
        for (int i = 0; i < 4; i++) begin drive(1, 1); drive(0, 10); end
        drive(1, 1); drive(0, 7);
        char_ready = 1'b1;
        drive(0, 1);
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pp_overflow: got %b want 0", overflow); end
        drive(0, 40);
        set_exp("EEEEE ");
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL pp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL pp_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mark();
        reset_dut();
        drive(1, 8); drive(0, 8);
        drive(1, 5);
        rst = 1'b1;
        drive(1, 1);
        rst = 1'b0;
        key = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests_run++;
        if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", char_valid); end
        got_q.delete();
        char_ready = 1'b1;
        drive(0, 10);
        drive(1, 8); drive(0, 8);
        drive(0, 30);
        set_exp("T ");
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL rst_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        string sym;
        int    nsym, hi, lo, last_lo;
        reset_dut();
        exp_q.delete();
        sym = "";
        last_lo = 0;
        rnd_ready = 1'b1;
        drive(0, 3);
        for (int c = 0; c < 40; c++) begin
            nsym = $urandom_range(1, 6);
            for (int s = 0; s < nsym; s++) begin
                if ($urandom_range(0, 1) == 1) hi = $urandom_range(2 * U, 4 * U);
                else                           hi = $urandom_range(1, 2 * U - 1);
                if (s != nsym - 1)               lo = $urandom_range(1, 2 * U - 1);
                else if ($urandom_range(0, 1) == 1) lo = $urandom_range(2 * U, 5 * U - 1);
                else                             lo = $urandom_range(5 * U, 6 * U);
                drive(1, hi);
                drive(0, lo);
                if (hi < 2 * U) sym = {sym, "."};
                else            sym = {sym, "-"};
                if (lo >= 2 * U) begin exp_q.push_back(lookup(sym)); sym = ""; end
                if (lo >= 5 * U) exp_q.push_back(8'h20);
                last_lo = lo;
            end
        end
        if (last_lo < 5 * U) exp_q.push_back(8'h20);
        drive(0, 6 * U);
        rnd_ready = 1'b0;
        char_ready = 1'b1;
        drive(0, 10);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL rnd_byte%0d: got %02h want %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rnd_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single_dot();
        test_threshold();
        test_digits();
        test_fifo_full();
        test_simul_push_pop();
        test_reset_mid_mark();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
